// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: host command
// bytes, FSM state encoding, write target selection and a state helper.
package program_loader_pkg;

  // Host command bytes
  localparam logic [7:0] LOADER_CMD_LOAD_I = 8'h01;
  localparam logic [7:0] LOADER_CMD_LOAD_D = 8'h02;
  localparam logic [7:0] LOADER_CMD_RUN    = 8'h03;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  // Which BRAM the current segment is written into
  typedef enum logic {
    TGT_IMEM = 1'b0,
    TGT_DMEM = 1'b1
  } loader_target_e;

  // States in which the loader is willing to take a host byte
  function automatic logic state_accepts_byte(input loader_state_e st);
    return (st == ST_CMD) || (st == ST_LEN_LO) || (st == ST_LEN_HI) || (st == ST_DATA);
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Little-endian byte-to-word packer. The first byte of a word ends up in
// bits 7:0. `word` already includes the byte being shifted this cycle, so
// the caller can capture the complete word on the same edge that
// `word_full` is reported.
module loader_word_packer (
  input  logic        clk,
  input  logic        rst,       // synchronous, active-low
  input  logic        clr,       // restart packing at byte 0
  input  logic        shift_en,  // accept din this cycle
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full  // din is the 4th byte of the word
);

  logic [31:0] shift_reg;
  logic [1:0]  byte_idx_reg;

  assign word      = {din, shift_reg[31:8]};
  assign word_full = shift_en && (byte_idx_reg == 2'd3);

  // Shift bytes in from the top; byte index wraps naturally after 4 bytes
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg    <= '0;
      byte_idx_reg <= '0;
    end else if (clr) begin
      shift_reg    <= '0;
      byte_idx_reg <= '0;
    end else if (shift_en) begin
      shift_reg    <= word;
      byte_idx_reg <= byte_idx_reg + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader for the rv32i_sc core: takes a valid/ready byte stream from
// the host, packs little-endian words into the instruction or data BRAM
// write port, and on RUN releases the PC and hands the data BRAM port to
// the core. All outputs except s_ready are registered.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,       // synchronous, active-low
  input  logic [7:0]            s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  pc_stall,
  output logic                  init_done,
  output logic                  err
);

  // Word index must represent 0..MAX_WORDS, one bit wider than a word address
  localparam int IDX_W = ADDR_WIDTH - 1;

  loader_state_e   state_reg, state_next;
  loader_target_e  target_reg, target_next;
  logic [15:0]     len_reg, len_next;
  logic [IDX_W-1:0] word_idx_reg, word_idx_next;

  logic [ADDR_WIDTH-1:0] i_w_addr_reg, i_w_addr_next;
  logic [DATA_WIDTH-1:0] i_w_dat_reg, i_w_dat_next;
  logic                  i_w_enb_reg, i_w_enb_next;
  logic [ADDR_WIDTH-1:0] d_w_addr_reg, d_w_addr_next;
  logic [DATA_WIDTH-1:0] d_w_dat_reg, d_w_dat_next;
  logic                  d_w_enb_reg, d_w_enb_next;
  logic                  pc_stall_reg, pc_stall_next;
  logic                  init_done_reg, init_done_next;
  logic                  err_reg, err_next;

  logic                  handshake;
  logic                  packer_clr;
  logic                  packer_shift;
  logic [31:0]           packed_word;
  logic                  packed_full;
  logic [15:0]           len_full;
  logic [IDX_W-1:0]      word_idx_inc;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] word_addr;

  // Ready is held low while reset is asserted even though the state is CMD
  assign s_ready   = rst && state_accepts_byte(state_reg);
  assign handshake = s_valid && s_ready;

  assign len_full     = {s_dat, len_reg[7:0]};
  assign word_idx_inc = word_idx_reg + {{(IDX_W-1){1'b0}}, 1'b1};
  assign last_word    = ({{(16-IDX_W){1'b0}}, word_idx_inc} == len_reg);
  assign word_addr    = {word_idx_reg[IDX_W-2:0], 2'b00};

  loader_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (packer_clr),
    .shift_en  (packer_shift),
    .din       (s_dat),
    .word      (packed_word),
    .word_full (packed_full)
  );

  // Next-state decode; write strobes/addresses are prepared one cycle ahead
  // so they are registered outputs during the WRITE state.
  always_comb begin
    state_next     = state_reg;
    target_next    = target_reg;
    len_next       = len_reg;
    word_idx_next  = word_idx_reg;
    i_w_addr_next  = i_w_addr_reg;
    i_w_dat_next   = i_w_dat_reg;
    i_w_enb_next   = 1'b0;
    d_w_addr_next  = d_w_addr_reg;
    d_w_dat_next   = d_w_dat_reg;
    d_w_enb_next   = 1'b0;
    packer_clr     = 1'b0;
    packer_shift   = 1'b0;

    case (state_reg)
      ST_CMD: begin
        if (handshake) begin
          case (s_dat)
            LOADER_CMD_LOAD_I: begin
              target_next = TGT_IMEM;
              state_next  = ST_LEN_LO;
            end
            LOADER_CMD_LOAD_D: begin
              target_next = TGT_DMEM;
              state_next  = ST_LEN_LO;
            end
            LOADER_CMD_RUN: state_next = ST_RUN;
            default:        state_next = ST_ERR;
          endcase
        end
      end

      ST_LEN_LO: begin
        if (handshake) begin
          len_next[7:0] = s_dat;
          state_next    = ST_LEN_HI;
        end
      end

      ST_LEN_HI: begin
        if (handshake) begin
          len_next = len_full;
          if (len_full == 16'd0) begin
            state_next = ST_CMD;
          end else if (len_full > 16'(MAX_WORDS)) begin
            state_next = ST_ERR;
          end else begin
            word_idx_next = '0;
            packer_clr    = 1'b1;
            state_next    = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        packer_shift = handshake;
        if (packed_full) begin
          state_next = ST_WRITE;
          if (target_reg == TGT_IMEM) begin
            i_w_enb_next  = 1'b1;
            i_w_addr_next = word_addr;
            i_w_dat_next  = DATA_WIDTH'(packed_word);
          end else begin
            d_w_enb_next  = 1'b1;
            d_w_addr_next = word_addr;
            d_w_dat_next  = DATA_WIDTH'(packed_word);
          end
        end
      end

      ST_WRITE: begin
        word_idx_next = word_idx_inc;
        state_next    = last_word ? ST_CMD : ST_DATA;
      end

      ST_RUN:  state_next = ST_RUN;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_ERR;
    endcase

    // Status flags follow the state being entered so they change together
    pc_stall_next  = (state_next != ST_RUN);
    init_done_next = (state_next == ST_RUN);
    err_next       = (state_next == ST_ERR);
  end

  // State and output registers; reset wins over everything, including a pending write
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_CMD;
      target_reg    <= TGT_IMEM;
      len_reg       <= '0;
      word_idx_reg  <= '0;
      i_w_addr_reg  <= '0;
      i_w_dat_reg   <= '0;
      i_w_enb_reg   <= 1'b0;
      d_w_addr_reg  <= '0;
      d_w_dat_reg   <= '0;
      d_w_enb_reg   <= 1'b0;
      pc_stall_reg  <= 1'b1;
      init_done_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      target_reg    <= target_next;
      len_reg       <= len_next;
      word_idx_reg  <= word_idx_next;
      i_w_addr_reg  <= i_w_addr_next;
      i_w_dat_reg   <= i_w_dat_next;
      i_w_enb_reg   <= i_w_enb_next;
      d_w_addr_reg  <= d_w_addr_next;
      d_w_dat_reg   <= d_w_dat_next;
      d_w_enb_reg   <= d_w_enb_next;
      pc_stall_reg  <= pc_stall_next;
      init_done_reg <= init_done_next;
      err_reg       <= err_next;
    end
  end

  assign i_w_addr  = i_w_addr_reg;
  assign i_w_dat   = i_w_dat_reg;
  assign i_w_enb   = i_w_enb_reg;
  assign d_w_addr  = d_w_addr_reg;
  assign d_w_dat   = d_w_dat_reg;
  assign d_w_enb   = d_w_enb_reg;
  assign pc_stall  = pc_stall_reg;
  assign init_done = init_done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the driver pushes the expected BRAM
// write as soon as the 4th byte of a word has been transferred; a monitor
// pops and compares on every write strobe, including the one-cycle latency.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_dat = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [9:0]  i_w_addr;
  logic [31:0] i_w_dat;
  logic        i_w_enb;
  logic [9:0]  d_w_addr;
  logic [31:0] d_w_dat;
  logic        d_w_enb;
  logic        pc_stall;
  logic        init_done;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_d;
    logic [9:0]  addr;
    logic [31:0] dat;
    time         t;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  logic [31:0] data_buf [0:255];

  program_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_dat     (s_dat),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .i_w_addr  (i_w_addr),
    .i_w_dat   (i_w_dat),
    .i_w_enb   (i_w_enb),
    .d_w_addr  (d_w_addr),
    .d_w_dat   (d_w_dat),
    .d_w_enb   (d_w_enb),
    .pc_stall  (pc_stall),
    .init_done (init_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input int idx, input logic [31:0] d);
    wr_t e;
    e.is_d = is_d;
    e.addr = 10'(idx * 4);
    e.dat  = d;
    e.t    = $time;
    sb.push_back(e);
  endtask

  // Offer one byte and return just after the edge that transfers it
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    s_dat   = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got s_ready=0 expected 1 for byte %h", b);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 1; i < k; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    s_valid = 1'b0;
    s_dat   = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_pc_stall", 32'(pc_stall), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wenb", {30'd0, i_w_enb, d_w_enb}, 32'd0);
    chk("rst_addr_dat", 32'(i_w_addr) | i_w_dat | 32'(d_w_addr) | d_w_dat, 32'd0);
    rst = 1'b1;
  endtask

  // Load data_buf[0..n-1] as a segment; model word = bytes little-endian
  task automatic send_load(input logic [7:0] cmd, input int n, input int gap_pct);
    send_byte(cmd);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
        send_byte(data_buf[w][8*b +: 8]);
        if (b == 3) push_exp(cmd == 8'h02, w, data_buf[w]);
      end
    end
  endtask

  task automatic expect_drained(input string name);
    idle(2);
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Write monitor: every strobe must match the oldest expectation
  always @(negedge clk) begin
    if (i_w_enb && d_w_enb) begin
      checks++;
      errors++;
      $display("FAIL both_enb: got i_w_enb=1 d_w_enb=1 expected at most one");
    end
    if (i_w_enb || d_w_enb) begin
      checks++;
      $display("write %s addr=%h dat=%h", d_w_enb ? "D" : "I",
               d_w_enb ? d_w_addr : i_w_addr, d_w_enb ? d_w_dat : i_w_dat);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %s write addr=%h expected none",
                 d_w_enb ? "D" : "I", d_w_enb ? d_w_addr : i_w_addr);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_d !== d_w_enb ||
            (d_w_enb ? d_w_addr : i_w_addr) !== mon_e.addr ||
            (d_w_enb ? d_w_dat : i_w_dat) !== mon_e.dat ||
            ($time - mon_e.t) != 5) begin
          errors++;
          $display("FAIL write_cmp: got port=%0d addr=%h dat=%h lat=%0t expected port=%0d addr=%h dat=%h lat=5",
                   d_w_enb, d_w_enb ? d_w_addr : i_w_addr, d_w_enb ? d_w_dat : i_w_dat,
                   $time - mon_e.t, mon_e.is_d, mon_e.addr, mon_e.dat);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bad;
    int         n;
    int         len;

    // Reset
    do_reset();

    // LOAD_I with two fixed words
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    push_exp(1'b0, 0, 32'h00500013);
    send_byte(8'hB3); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    push_exp(1'b0, 1, 32'h000000B3);
    expect_drained("loadi_drain");

    // LOAD_D with a 3-cycle valid gap inside the word
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    idle(3);
    send_byte(8'h00); send_byte(8'h00);
    push_exp(1'b1, 0, 32'h00000001);
    expect_drained("loadd_drain");
    chk("load_pc_stall", 32'(pc_stall), 32'd1);

    // Error: unknown command
    do_reset();
    send_byte(8'h7F);
    idle(1);
    chk("badcmd_err", 32'(err), 32'd1);
    chk("badcmd_s_ready", 32'(s_ready), 32'd0);

    // Error: length one above the maximum
    do_reset();
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h01);
    idle(1);
    chk("len257_err", 32'(err), 32'd1);
    expect_drained("len257_nowrite");

    // Zero length returns to CMD without writes
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    idle(1);
    chk("len0_ready", 32'(s_ready), 32'd1);
    chk("len0_err", 32'(err), 32'd0);
    expect_drained("len0_nowrite");

    // Mid-word reset discards the partial word
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    do_reset();
    data_buf[0] = 32'hAABBCCDD;
    send_load(8'h01, 1, 0);
    expect_drained("midrst_drain");

    // Maximum-length data segment
    for (int w = 0; w < 256; w++) data_buf[w] = $urandom;
    send_load(8'h02, 256, 5);
    expect_drained("max_len_drain");

    // Randomized segments and error injections
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 9))
        0: begin
          bad = 8'($urandom_range(4, 255));
          send_byte(bad);
          idle(1);
          chk("rand_badcmd_err", 32'(err), 32'd1);
          do_reset();
        end
        1: begin
          len = $urandom_range(257, 65535);
          send_byte(8'h02); send_byte(len[7:0]); send_byte(len[15:8]);
          idle(1);
          chk("rand_longlen_err", 32'(err), 32'd1);
          expect_drained("rand_longlen_nowrite");
          do_reset();
        end
        default: begin
          n = $urandom_range(1, 8);
          for (int w = 0; w < n; w++) data_buf[w] = $urandom;
          send_load($urandom_range(0, 1) ? 8'h02 : 8'h01, n, 30);
          expect_drained("rand_load_drain");
          chk("rand_load_err", 32'(err), 32'd0);
        end
      endcase
    end

    // RUN hands over control; later bytes are ignored
    send_byte(8'h03);
    idle(1);
    chk("run_pc_stall", 32'(pc_stall), 32'd0);
    chk("run_init_done", 32'(init_done), 32'd1);
    chk("run_s_ready", 32'(s_ready), 32'd0);
    s_dat   = 8'h01;
    s_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("run_ignore_ready", 32'(s_ready), 32'd0);
    chk("run_hold_pc_stall", 32'(pc_stall), 32'd0);
    expect_drained("run_nowrite");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
